liteeth_sram_fifo_ctrl: RTL



---
 rtl/liteeth_sram_fifo_pkg.sv | 25 ++
 rtl/liteeth_sram_fifo_obuf.sv | 65 ++++++
 rtl/liteeth_sram_fifo_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/liteeth_sram_fifo_pkg.sv
// Shared widths, types and the pointer wrap helper for the LiteEth SRAM FIFO
// controller. The optional watermark outputs are built only when
// LITEETH_SRAM_FIFO_WATERMARK_EN is defined; the thresholds live here.
package liteeth_sram_fifo_pkg;

  localparam int BITS        = 32;
  localparam int WORD_DEPTH  = 384;
  localparam int ADDR_WIDTH  = 9;
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;
  localparam int AFULL_TH    = 368;
  localparam int AEMPTY_TH   = 16;

  typedef logic [ADDR_WIDTH-1:0]  ptr_t;
  typedef logic [LEVEL_WIDTH-1:0] level_t;
  typedef logic [BITS-1:0]        word_t;

  // Depth is not a power of two, so the wrap back to zero is explicit.
  function automatic ptr_t next_ptr(input ptr_t p);
    if (p == ptr_t'(WORD_DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/liteeth_sram_fifo_obuf.sv
// Two-entry first-word-first-out output buffer. It hides the SRAM read
// latency: a word read in one cycle is captured here the next cycle and
// presented on out_data. Capture and pop in the same cycle are both honoured.
module liteeth_sram_fifo_obuf
  import liteeth_sram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       capture,
  input  word_t      cap_data,
  input  logic       pop,
  output logic       out_valid,
  output word_t      out_data,
  output logic [1:0] buf_cnt
);

  word_t      head_q, head_d;
  word_t      tail_q, tail_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop_eff;

  // Next-state: shift on pop, then place the captured word behind what remains.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    pop_eff = pop & (cnt_q != 2'd0);
    if (pop_eff) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (capture) begin
      if (cnt_d == 2'd0) begin
        head_d = cap_data;
      end else begin
        tail_d = cap_data;
      end
      cnt_d = cnt_d + 2'd1;
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign buf_cnt   = cnt_q;

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Streaming FIFO controller around a 1rw1r 32x384 SRAM macro. The rw port
// only writes, the r port prefetches into a 2-entry output buffer so both
// sides sustain one word per cycle. Watermark flags are built only when
// LITEETH_SRAM_FIFO_WATERMARK_EN is defined; otherwise they are tied low.
module liteeth_sram_fifo_ctrl
  import liteeth_sram_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  sram_rw_ce,
  output logic                  sram_rw_we,
  output logic [ADDR_WIDTH-1:0] sram_rw_addr,
  output logic [BITS-1:0]       sram_rw_wd,
  output logic                  sram_r_ce,
  output logic [ADDR_WIDTH-1:0] sram_r_addr,
  input  logic [BITS-1:0]       sram_r_rd
);

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  level_t     sram_cnt_q, sram_cnt_d;
  logic       inflight_q, inflight_d;
  level_t     level_q, level_d;

  logic       pop;
  logic       wr_en;
  logic       rd_en;
  logic       capture;
  logic [1:0] buf_cnt;
  logic [2:0] occ;
  logic [2:0] buf_nx;

  liteeth_sram_fifo_obuf u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .capture   (capture),
    .cap_data  (sram_r_rd),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .buf_cnt   (buf_cnt)
  );

  // Handshakes and port strobes. A read is issued only if the buffer plus the
  // word already in flight leaves room after this cycle's pop.
  always_comb begin
    pop      = out_valid & out_ready;
    in_ready = rst_n & ~flush & (sram_cnt_q < level_t'(WORD_DEPTH));
    wr_en    = in_valid & in_ready;
    occ      = {1'b0, buf_cnt} + {2'b00, inflight_q};
    rd_en    = ~flush & (sram_cnt_q != '0) & (occ < (3'd2 + {2'b00, pop}));
    capture  = inflight_q & ~flush;
  end

  assign sram_rw_ce   = wr_en;
  assign sram_rw_we   = wr_en;
  assign sram_rw_addr = wr_ptr_q;
  assign sram_rw_wd   = in_data;
  assign sram_r_ce    = rd_en;
  assign sram_r_addr  = rd_ptr_q;

  // Next-state for pointers, SRAM count, in-flight flag and the level sum.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    inflight_d = rd_en;
    if (wr_en) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({wr_en, rd_en})
      2'b10:   sram_cnt_d = sram_cnt_q + level_t'(1);
      2'b01:   sram_cnt_d = sram_cnt_q - level_t'(1);
      default: sram_cnt_d = sram_cnt_q;
    endcase
    buf_nx  = {1'b0, buf_cnt} + {2'b00, capture} - {2'b00, pop};
    level_d = sram_cnt_d + level_t'(inflight_d) + level_t'(buf_nx);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sram_cnt_d = '0;
      inflight_d = 1'b0;
      level_d    = '0;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      level_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      level_q    <= level_d;
    end
  end

  assign level = level_q;

`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  logic afull_q;
  logic aempty_q;

  // Watermarks track the same next value that loads level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= (level_d >= level_t'(AFULL_TH));
      aempty_q <= (level_d <= level_t'(AEMPTY_TH));
    end
  end

  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule
